clarke_park_transform: RTL and testbench
========================================

# clarke_park_transform

- Converts two phase-current ADC samples and the electrical rotor angle into d/q-axis currents (Clarke, then Park).
- Sits directly upstream of the current-loop PI:
  - oId/oIq drive its iCurrent_d/iCurrent_q.
  - oCal_done drives its iCal_en.
- Uses one registered sine/cosine LUT and a fixed 6-state pipeline.
- Produces one result per iCal_en rising edge.

## Interface
Parameters:
- LUT_AW, 10, quarter-wave table address width (4096 angle steps per electrical revolution)
- I_MAX, 2047, output saturation magnitude (matches the PI error clamp)

Ports:
- iClk  in  1  clock
- iRst_n  in  1  reset: one clock; reset is synchronous and active-low
- iIa  in  12 signed  phase A current, ADC counts
- iIb  in  12 signed  phase B current, ADC counts
- iTheta  in  12 unsigned  electrical angle, 0..4095 = 0..360°
- iCal_en  in  1  start; rising edge triggers a conversion
- oId  out  12 signed  d-axis current
- oIq  out  12 signed  q-axis current
- oCal_done  out  1  one-cycle pulse when oId/oIq update

## Operation
- Edge detect:
  - iCal_en is registered into en_prev (reset 0).
  - Trigger = iCal_en & !en_prev, evaluated only in S_IDLE.
  - Triggers in any other state are ignored, not queued.
- FSM: S_IDLE → S_CLARKE → S_BETA → S_MUL → S_SUM → S_SAT → S_IDLE.
  - No stalls, no other transitions.
  - Illegal encodings go to S_IDLE.
- S_IDLE: on trigger, latch iIa, iIb and iTheta.
- S_CLARKE:
  - s = Ia + 2·Ib, 14-bit signed.
  - Present theta to the LUT.
- S_BETA:
  - Ibeta = rescale(s·18919), 13-bit signed, never saturated.
  - 18919 = round(2^15/√3).
  - LUT sin/cos outputs are valid in this state.
- S_MUL: register four 30-bit signed products: Ia·cos, Ibeta·sin, Ia·sin, Ibeta·cos.
- S_SUM:
  - d = rescale(Ia·cos + Ibeta·sin).
  - q = rescale(Ibeta·cos − Ia·sin).
  - Both are 30-bit sums rescaled to 15-bit signed.
- S_SAT:
  - Clamp d and q to [−I_MAX, +I_MAX] and register them into oId/oIq.
  - Assert oCal_done.
- rescale(x) = x >>> 15, arithmetic (see Configuration for rounding).
- Sine/cosine:
  - Q15 signed 16-bit; T[k] = round(32767·sin(2πk/4096)), k = 0..1024.
  - T[1024] = 32767.
  - idx = theta[9:0], quadrant = theta[11:10].
  - sin by quadrant: q0 T[idx]; q1 T[1024−idx]; q2 −T[idx]; q3 −T[1024−idx].
  - cos(θ) = sin(θ + 1024 mod 4096).
- Reset values: oId = 0, oIq = 0, oCal_done = 0, state S_IDLE, en_prev = 0, all pipeline registers 0.
- Reset mid-conversion: the conversion is abandoned and no done pulse is produced.
  - If iCal_en is high on the first cycle after reset release, it counts as a rising edge.

## Timing
- Trigger sampled at edge k.
- oId, oIq and oCal_done all update at edge k+5.
- oCal_done is high for exactly one cycle (k+5 to k+6).
- Back in S_IDLE after edge k+5; the next trigger is accepted at edge k+6 at the earliest.
  - Maximum rate: one conversion per 6 cycles.
- oId/oIq hold their value until the next S_SAT.
- iIa, iIb and iTheta may change freely after edge k.

## Configuration
- PARK_ROUND_EN defined: every rescale adds 2^14 before the >>> 15 (round half up). Applies to Ibeta, d and q.
- PARK_ROUND_EN undefined: plain >>> 15 (truncate toward −∞).
- No port or latency difference between the two builds.

## Structure
- Shared package (e.g. foc_pkg) holds:
  - Q15 constants: INV_SQRT3_Q15 = 18919, Q15_ONE = 32767.
  - I_MAX.
  - The angle width (12).
  - The FSM state enumeration.
- Sub-module sin_cos_lut:
  - Input: 12-bit angle.
  - Outputs: registered 16-bit signed sin/cos, 1-cycle latency.
  - Holds the quarter-wave ROM and the quadrant folding.
  - Reusable by the downstream inverse-Park stage.

## Test plan
1. θ=0, Ia=1000, Ib=0:
   - With ROUND: Id=1000, Iq=577.
   - Without: Id=999, Iq=576.
   - Done at k+5 in both builds.
2. θ=1024, Ia=1000, Ib=0:
   - With ROUND: Id=577, Iq=−1000.
   - Without: Id=576, Iq=−1000.
3. θ=0, Ia=Ib=2047: Iq saturates to +2047; Id=2047 (ROUND) or 2046 (trunc). Repeat with Ia=Ib=−2048: Iq saturates to −2047.
4. θ=2048, Ia=1000, Ib=0: Id=−1000, Iq=−577 (both builds). Covers the negative-cos path.
5. iCal_en held high for 20 cycles → exactly one oCal_done pulse. Then pulse iCal_en again at k+3 (while busy) → ignored, no second done.
6. Assert iRst_n=0 at k+3 of a conversion → outputs 0 and no done pulse. Release with iCal_en=1 → a new conversion completes 5 cycles after the first post-reset edge.

Source files
------------

// File: rtl/clarke_park_transform_pkg.sv
// clarke_park_transform_pkg: Q15 constants, current limit, angle width, FSM states and quarter-wave sine generator
package clarke_park_transform_pkg;
  localparam int ANGLE_W = 12;
  localparam int INV_SQRT3_Q15 = 18919;
  localparam int Q15_ONE = 32767;
  localparam int I_MAX = 2047;
  typedef enum logic [2:0] {S_IDLE, S_CLARKE, S_BETA, S_MUL, S_SUM, S_SAT} state_t;
  function automatic logic signed [15:0] q15_sin(input int k, input int aw);
    logic signed [127:0] x, x2, term, sum;
    x = ((128'(k) * 128'd314159265358979323846) << (55 - aw)) / 128'd100000000000000000000;
    x2 = (x * x) >>> 56;
    term = x;
    sum = x;
    for (int n = 1; n < 14; n++) begin
      term = -(term * x2 >>> 56) / 128'(2 * n * (2 * n + 1));
      sum += term;
    end
    return 16'((sum * 128'(Q15_ONE) + (128'sd1 <<< 55)) >>> 56);
  endfunction
endpackage

// File: rtl/sin_cos_lut.sv
// sin_cos_lut: registered Q15 sine/cosine from a quadrant-folded quarter-wave table
module sin_cos_lut
  import clarke_park_transform_pkg::*;
#(
  parameter int LUT_AW = 10
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [LUT_AW+1:0]     theta,
  output logic signed [15:0]    sine,
  output logic signed [15:0]    cosine
);
  localparam int N = 2 ** LUT_AW;
  localparam logic [LUT_AW:0] FULL = {1'b1, {LUT_AW{1'b0}}};
  logic signed [15:0] rom [N+1];
  for (genvar k = 0; k <= N; k++) begin : g_rom
    localparam logic signed [15:0] V = q15_sin(k, LUT_AW);
    assign rom[k] = V;
  end
  logic [LUT_AW:0] idx_w, sin_a, cos_a;
  logic [1:0] qs, qc;
  always_comb begin
    idx_w = {1'b0, theta[LUT_AW-1:0]};
    qs = theta[LUT_AW+1:LUT_AW];
    qc = qs + 2'd1;
    sin_a = qs[0] ? FULL - idx_w : idx_w;
    cos_a = qc[0] ? FULL - idx_w : idx_w;
  end
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sine <= '0;
      cosine <= '0;
    end else begin
      sine <= qs[1] ? -rom[sin_a] : rom[sin_a];
      cosine <= qc[1] ? -rom[cos_a] : rom[cos_a];
    end
  end
endmodule

// File: rtl/clarke_park_transform.sv
// clarke_park_transform: phase currents and angle to clamped d/q currents; PARK_ROUND_EN selects round-half-up rescaling
module clarke_park_transform #(
  parameter int LUT_AW = 10,
  parameter int I_MAX = clarke_park_transform_pkg::I_MAX
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic signed [11:0] iIa,
  input  logic signed [11:0] iIb,
  input  logic [11:0]        iTheta,
  input  logic               iCal_en,
  output logic signed [11:0] oId,
  output logic signed [11:0] oIq,
  output logic               oCal_done
);
  import clarke_park_transform_pkg::*;
`ifdef PARK_ROUND_EN
  localparam logic signed [29:0] RND = 30'sd16384;
`else
  localparam logic signed [29:0] RND = 30'sd0;
`endif
  localparam logic signed [14:0] LIM = 15'(I_MAX);
  state_t state, state_n;
  logic en_prev, trig, ld_in, ld_s, ld_beta, ld_mul, ld_sum, ld_out;
  logic signed [11:0] ia_r, ib_r, d_sat, q_sat;
  logic [11:0] theta_r;
  logic signed [13:0] s_r, s_c;
  logic signed [12:0] ibeta_r;
  logic signed [15:0] sin_v, cos_v;
  logic signed [29:0] p_ac, p_bs, p_as, p_bc, beta_full, d_full, q_full;
  logic signed [14:0] d_r, q_r;
  sin_cos_lut #(.LUT_AW(LUT_AW)) u_lut (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .theta(theta_r),
    .sine(sin_v),
    .cosine(cos_v)
  );
  always_ff @(posedge iClk) state <= !iRst_n ? S_IDLE : state_n;
  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE:   state_n = trig ? S_CLARKE : S_IDLE;
      S_CLARKE: state_n = S_BETA;
      S_BETA:   state_n = S_MUL;
      S_MUL:    state_n = S_SUM;
      S_SUM:    state_n = S_SAT;
      default:  state_n = S_IDLE;
    endcase
  end
  always_comb begin
    trig = iCal_en && !en_prev;
    ld_in = state == S_IDLE && trig;
    ld_s = state == S_CLARKE;
    ld_beta = state == S_BETA;
    ld_mul = state == S_MUL;
    ld_sum = state == S_SUM;
    ld_out = state == S_SAT;
  end
  always_comb begin
    s_c = 14'(ia_r) + (14'(ib_r) <<< 1);
    beta_full = 30'(s_r) * 30'(INV_SQRT3_Q15) + RND;
    d_full = p_ac + p_bs + RND;
    q_full = p_bc - p_as + RND;
    d_sat = d_r > LIM ? 12'(LIM) : d_r < -LIM ? 12'(-LIM) : 12'(d_r);
    q_sat = q_r > LIM ? 12'(LIM) : q_r < -LIM ? 12'(-LIM) : 12'(q_r);
  end
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      en_prev <= 1'b0;
      ia_r <= '0;
      ib_r <= '0;
      theta_r <= '0;
      s_r <= '0;
      ibeta_r <= '0;
      p_ac <= '0;
      p_bs <= '0;
      p_as <= '0;
      p_bc <= '0;
      d_r <= '0;
      q_r <= '0;
      oId <= '0;
      oIq <= '0;
      oCal_done <= 1'b0;
    end else begin
      en_prev <= iCal_en;
      oCal_done <= ld_out;
      if (ld_in) begin
        ia_r <= iIa;
        ib_r <= iIb;
        theta_r <= iTheta;
      end
      if (ld_s) s_r <= s_c;
      if (ld_beta) ibeta_r <= 13'(beta_full >>> 15);
      if (ld_mul) begin
        p_ac <= 30'(ia_r) * 30'(cos_v);
        p_bs <= 30'(ibeta_r) * 30'(sin_v);
        p_as <= 30'(ia_r) * 30'(sin_v);
        p_bc <= 30'(ibeta_r) * 30'(cos_v);
      end
      if (ld_sum) begin
        d_r <= 15'(d_full >>> 15);
        q_r <= 15'(q_full >>> 15);
      end
      if (ld_out) begin
        oId <= d_sat;
        oIq <= q_sat;
      end
    end
  end
endmodule

// File: tb/tb_clarke_park_transform.sv
// tb_clarke_park_transform: vector table, random model comparison, trigger and reset corner cases
module tb_clarke_park_transform;
  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  logic iCal_en = 1'b0;
  logic signed [11:0] iIa = '0;
  logic signed [11:0] iIb = '0;
  logic [11:0] iTheta = '0;
  logic signed [11:0] oId, oIq;
  logic oCal_done;
  int errors = 0;
  int checks = 0;
  int tbl [0:1024];
  typedef struct {int ia; int ib; int th; int d; int q;} vec_t;
`ifdef PARK_ROUND_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  clarke_park_transform dut (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .iIa(iIa),
    .iIb(iIb),
    .iTheta(iTheta),
    .iCal_en(iCal_en),
    .oId(oId),
    .oIq(oIq),
    .oCal_done(oCal_done)
  );
  always #5 iClk = ~iClk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask
  function automatic int sin_m(input int th);
    int idx, qd, m;
    idx = th % 1024;
    qd = th / 1024;
    m = (qd % 2 == 1) ? tbl[1024 - idx] : tbl[idx];
    return qd >= 2 ? -m : m;
  endfunction
  function automatic longint rs(input longint x);
`ifdef PARK_ROUND_EN
    return (x + 16384) >>> 15;
`else
    return x >>> 15;
`endif
  endfunction
  function automatic int clamp(input longint x);
    return x > 2047 ? 2047 : x < -2047 ? -2047 : int'(x);
  endfunction
  task automatic model(input int ia, input int ib, input int th, output int d, output int q);
    longint ibeta, s, c;
    ibeta = rs(longint'(ia + 2 * ib) * 18919);
    s = sin_m(th);
    c = sin_m((th + 1024) % 4096);
    d = clamp(rs(ia * c + ibeta * s));
    q = clamp(rs(ibeta * c - ia * s));
  endtask
  task automatic start(input int ia, input int ib, input int th);
    @(negedge iClk);
    iIa = 12'(ia);
    iIb = 12'(ib);
    iTheta = 12'(th);
    iCal_en = 1'b1;
    @(posedge iClk);
    #1;
    iCal_en = 1'b0;
    iIa = 12'($urandom);
    iIb = 12'($urandom);
    iTheta = 12'($urandom);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge iClk);
      #1;
      if (oCal_done) lat = i;
    end
  endtask
  task automatic run(input string nm, input int ia, input int ib, input int th, input int ed, input int eq);
    int lat;
    start(ia, ib, th);
    wait_done(lat);
    chk({nm, " latency"}, lat, 5);
    chk({nm, " id"}, int'(oId), ed);
    chk({nm, " iq"}, int'(oIq), eq);
    @(posedge iClk);
    #1 chk({nm, " pulse width"}, int'(oCal_done), 0);
  endtask
  initial begin
    vec_t v [6];
    int bnd [5];
    int d, q, lat, n, at;
    for (int k = 0; k <= 1024; k++) tbl[k] = $rtoi(32767.0 * $sin(3.14159265358979323846 * k / 2048.0) + 0.5);
    v[0] = '{1000, 0, 0, 999 + R, 576 + R};
    v[1] = '{1000, 0, 1024, 576 + R, -1000};
    v[2] = '{2047, 2047, 0, 2046 + R, 2047};
    v[3] = '{-2048, -2048, 0, -2047, -2047};
    v[4] = '{1000, 0, 2048, -1000, -577};
    v[5] = '{0, 0, 777, 0, 0};
    bnd = '{1023, 1024, 3071, 3072, 4095};
    repeat (3) @(posedge iClk);
    #1;
    chk("reset id", int'(oId), 0);
    chk("reset iq", int'(oIq), 0);
    chk("reset done", int'(oCal_done), 0);
    @(negedge iClk) iRst_n = 1'b1;
    foreach (v[i]) run($sformatf("vec%0d", i), v[i].ia, v[i].ib, v[i].th, v[i].d, v[i].q);
    for (int i = 0; i < 40; i++) begin
      int ia, ib, th;
      ia = int'($urandom_range(4095)) - 2048;
      ib = int'($urandom_range(4095)) - 2048;
      th = i < 5 ? bnd[i] : int'($urandom_range(4095));
      model(ia, ib, th, d, q);
      run($sformatf("rand%0d ia=%0d ib=%0d th=%0d", i, ia, ib, th), ia, ib, th, d, q);
    end
    @(negedge iClk) iCal_en = 1'b1;
    n = 0;
    repeat (20) begin
      @(posedge iClk);
      #1 n += int'(oCal_done);
    end
    iCal_en = 1'b0;
    repeat (8) begin
      @(posedge iClk);
      #1 n += int'(oCal_done);
    end
    chk("held enable pulses", n, 1);
    start(500, -300, 700);
    n = 0;
    at = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge iClk);
      #1;
      if (oCal_done) begin
        n++;
        at = i;
        model(500, -300, 700, d, q);
        chk("busy id", int'(oId), d);
        chk("busy iq", int'(oIq), q);
      end
      iCal_en = (i == 2);
    end
    chk("busy pulses", n, 1);
    chk("busy latency", at, 5);
    start(1500, 200, 300);
    repeat (2) @(posedge iClk);
    #1 iRst_n = 1'b0;
    @(posedge iClk);
    #1;
    chk("midrst id", int'(oId), 0);
    chk("midrst iq", int'(oIq), 0);
    chk("midrst done", int'(oCal_done), 0);
    iIa = -12'sd700;
    iIb = 12'sd900;
    iTheta = 12'd2500;
    iCal_en = 1'b1;
    iRst_n = 1'b1;
    @(posedge iClk);
    #1;
    iCal_en = 1'b0;
    iIa = 12'($urandom);
    wait_done(lat);
    model(-700, 900, 2500, d, q);
    chk("post-rst latency", lat, 5);
    chk("post-rst id", int'(oId), d);
    chk("post-rst iq", int'(oIq), q);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
